// File: rtl/aes_block_sequencer.sv
// Host-side sequencer for the AES datapath: loads one 128-bit block into the
// data columns, kicks the control unit, waits for completion and reads the result back.
module aes_block_sequencer #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [127:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_data,
   output logic [31:0]  bus_out,
   output logic [3:0]   col_en_host,
   output logic [1:0]   col_sel_host,
   output logic         start,
   input  logic         end_aes,
   input  logic [31:0]  col_bus,
   output logic         busy,
   output logic         err
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_BUSY,
      S_READ,
      S_OUT
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     k_q, k_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [127:0]   hold_q, hold_d;
   logic [127:0]   mdata_q, mdata_d;
   logic           err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= 2'd0;
         cnt_q   <= '0;
         hold_q  <= '0;
         mdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         mdata_q <= mdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      mdata_d = mdata_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (s_valid) begin
               hold_d  = s_data;
               k_d     = 2'd0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) state_d = S_START;
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_BUSY;
         end
         S_BUSY: begin
            // Completion in the final counted cycle still wins over the timeout.
            if (end_aes) begin
               k_d     = 2'd0;
               state_d = S_READ;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_READ: begin
            // Word k lives at bit offset 32*(3-k); ~k is 3-k for a 2-bit index.
            mdata_d[{~k_q, 5'b0} +: 32] = col_bus;
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) state_d = S_OUT;
         end
         S_OUT: begin
            if (m_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      s_ready      = (state_q == S_IDLE) && rst_n;
      m_valid      = (state_q == S_OUT);
      busy         = (state_q != S_IDLE);
      start        = (state_q == S_START);
      bus_out      = 32'd0;
      col_en_host  = 4'd0;
      col_sel_host = 2'd0;
      if (state_q == S_LOAD) begin
         bus_out     = hold_q[{~k_q, 5'b0} +: 32];
         col_en_host = 4'b0001 << k_q;
      end
      if (state_q == S_READ) col_sel_host = k_q;
   end

   assign m_data = mdata_q;
   assign err    = err_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer: a default-timeout instance for the data
// path scenarios and a TIMEOUT=8 instance for the abort scenarios.
module tb_aes_block_sequencer;

   localparam logic [127:0] EXP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] EXP_OUT = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         s_valid = 1'b0, s_valid2 = 1'b0;
   logic [127:0] s_data = '0;
   logic         m_ready = 1'b0;
   logic         end_aes = 1'b0, end_aes2 = 1'b0;
   logic         s_ready, m_valid, start, busy, err;
   logic [127:0] m_data;
   logic [31:0]  bus_out, col_bus;
   logic [3:0]   col_en_host;
   logic [1:0]   col_sel_host;
   logic         s_ready2, m_valid2, start2, busy2, err2;
   logic [127:0] m_data2;
   logic [31:0]  bus_out2, col_bus2;
   logic [3:0]   col_en_host2;
   logic [1:0]   col_sel_host2;

   int errors = 0;
   int checks = 0;
   logic [31:0] in_w [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

   always #5 clk = ~clk;

   function automatic logic [31:0] result_word(input logic [1:0] sel);
      case (sel)
         2'd0:    return 32'h69c4e0d8;
         2'd1:    return 32'h6a7b0430;
         2'd2:    return 32'hd8cdb780;
         default: return 32'h70b4c55a;
      endcase
   endfunction

   assign col_bus  = result_word(col_sel_host);
   assign col_bus2 = result_word(col_sel_host2);

   aes_block_sequencer dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .bus_out(bus_out),
      .col_en_host(col_en_host), .col_sel_host(col_sel_host), .start(start),
      .end_aes(end_aes), .col_bus(col_bus), .busy(busy), .err(err)
   );

   aes_block_sequencer #(.TIMEOUT(8)) dut_t (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data),
      .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .bus_out(bus_out2),
      .col_en_host(col_en_host2), .col_sel_host(col_sel_host2), .start(start2),
      .end_aes(end_aes2), .col_bus(col_bus2), .busy(busy2), .err(err2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshake a block and step through LOAD and START; returns in the first BUSY cycle.
   task automatic load_and_start(input logic [127:0] data);
      s_valid = 1'b1;
      s_data  = data;
      tick();
      s_valid = 1'b0;
      repeat (5) tick();
   endtask

   // Pulse end_aes in the current BUSY cycle; returns in the first OUT cycle.
   task automatic read_out();
      end_aes = 1'b1;
      tick();
      end_aes = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if ({start, err} !== 2'b00) begin errors++; $display("FAIL rst_start_err got %b want 00", {start, err}); end
      checks++; if ({bus_out, col_en_host, col_sel_host} !== 38'd0) begin errors++; $display("FAIL rst_dp_outs got %h want 0", {bus_out, col_en_host, col_sel_host}); end
      checks++; if (m_data !== 128'd0) begin errors++; $display("FAIL rst_m_data got %h want 0", m_data); end
      rst_n = 1'b1;
      tick();
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_s_ready got %b want 1", s_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy got %b want 0", busy); end
   endtask

   task automatic test_single_block();
      s_valid = 1'b1;
      s_data  = EXP_IN;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL single_s_ready got %b want 1", s_ready); end
      tick();
      s_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus_out !== in_w[i]) begin errors++; $display("FAIL load_bus_out[%0d] got %h want %h", i, bus_out, in_w[i]); end
         checks++; if (col_en_host !== (4'b0001 << i)) begin errors++; $display("FAIL load_col_en[%0d] got %b want %b", i, col_en_host, 4'b0001 << i); end
         checks++; if (busy !== 1'b1 || start !== 1'b0) begin errors++; $display("FAIL load_busy_start[%0d] got %b%b want 10", i, busy, start); end
         tick();
      end
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL start_cycle5 got %b want 1", start); end
      checks++; if ({bus_out, col_en_host} !== 36'd0) begin errors++; $display("FAIL start_dp_idle got %h want 0", {bus_out, col_en_host}); end
      tick();
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_one_cycle got %b want 0", start); end
      repeat (19) tick();
      checks++; if (busy !== 1'b1 || m_valid !== 1'b0 || col_sel_host !== 2'd0) begin errors++; $display("FAIL busy_wait got busy=%b m_valid=%b sel=%0d want 1 0 0", busy, m_valid, col_sel_host); end
      end_aes = 1'b1;
      tick();
      end_aes = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (col_sel_host !== 2'(i)) begin errors++; $display("FAIL read_col_sel[%0d] got %0d want %0d", i, col_sel_host, i); end
         checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL read_m_valid[%0d] got %b want 0", i, m_valid); end
         tick();
      end
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL out_m_valid got %b want 1", m_valid); end
      checks++; if (m_data !== EXP_OUT) begin errors++; $display("FAIL out_m_data got %h want %h", m_data, EXP_OUT); end
      checks++; if (col_sel_host !== 2'd0) begin errors++; $display("FAIL out_col_sel got %0d want 0", col_sel_host); end
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      repeat (7) begin
         tick();
         checks++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL bp_handshake got m_valid=%b s_ready=%b want 1 0", m_valid, s_ready); end
         checks++; if (m_data !== EXP_OUT) begin errors++; $display("FAIL bp_m_data got %h want %h", m_data, EXP_OUT); end
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got s_ready=%b m_valid=%b busy=%b want 1 0 0", s_ready, m_valid, busy); end
   endtask

   task automatic test_timeout();
      s_valid2 = 1'b1;
      tick();
      s_valid2 = 1'b0;
      repeat (4) tick();
      checks++; if (start2 !== 1'b1) begin errors++; $display("FAIL to_start got %b want 1", start2); end
      tick();
      for (int i = 0; i < 8; i++) begin
         checks++; if (busy2 !== 1'b1 || err2 !== 1'b0 || m_valid2 !== 1'b0) begin errors++; $display("FAIL to_busy[%0d] got busy=%b err=%b m_valid=%b want 1 0 0", i, busy2, err2, m_valid2); end
         tick();
      end
      checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", err2); end
      checks++; if (busy2 !== 1'b0 || s_ready2 !== 1'b1 || m_valid2 !== 1'b0) begin errors++; $display("FAIL to_idle got busy=%b s_ready=%b m_valid=%b want 0 1 0", busy2, s_ready2, m_valid2); end
      checks++; if (m_data2 !== 128'd0) begin errors++; $display("FAIL to_m_data got %h want 0", m_data2); end
      s_valid2 = 1'b1;
      tick();
      s_valid2 = 1'b0;
      checks++; if (err2 !== 1'b0 || busy2 !== 1'b1) begin errors++; $display("FAIL to_reaccept got err=%b busy=%b want 0 1", err2, busy2); end
      repeat (5) tick();
      repeat (7) tick();
      end_aes2 = 1'b1;
      tick();
      end_aes2 = 1'b0;
      checks++; if (err2 !== 1'b0 || busy2 !== 1'b1) begin errors++; $display("FAIL to_last_end_wins got err=%b busy=%b want 0 1", err2, busy2); end
      repeat (4) tick();
      checks++; if (m_valid2 !== 1'b1 || m_data2 !== EXP_OUT) begin errors++; $display("FAIL to_late_result got v=%b d=%h want 1 %h", m_valid2, m_data2, EXP_OUT); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   task automatic test_spurious_end();
      s_valid = 1'b1;
      s_data  = EXP_IN;
      end_aes = 1'b1;
      tick();
      s_valid = 1'b0;
      repeat (4) tick();
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL spur_start got %b want 1", start); end
      tick();
      end_aes = 1'b0;
      repeat (3) tick();
      checks++; if (busy !== 1'b1 || m_valid !== 1'b0 || col_sel_host !== 2'd0 || start !== 1'b0) begin errors++; $display("FAIL spur_still_busy got busy=%b v=%b sel=%0d start=%b want 1 0 0 0", busy, m_valid, col_sel_host, start); end
      read_out();
      checks++; if (m_valid !== 1'b1 || m_data !== EXP_OUT) begin errors++; $display("FAIL spur_result got v=%b d=%h want 1 %h", m_valid, m_data, EXP_OUT); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      load_and_start(128'hdeadbeef_01234567_89abcdef_fedcba98);
      end_aes = 1'b1;
      tick();
      end_aes = 1'b0;
      repeat (2) tick();
      checks++; if (col_sel_host !== 2'd2) begin errors++; $display("FAIL mid_read_sel got %0d want 2", col_sel_host); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({s_ready, m_valid, busy, start, err} !== 5'd0) begin errors++; $display("FAIL mid_rst_ctrl got %b want 00000", {s_ready, m_valid, busy, start, err}); end
      checks++; if ({bus_out, col_en_host, col_sel_host} !== 38'd0 || m_data !== 128'd0) begin errors++; $display("FAIL mid_rst_data got %h/%h want 0", {bus_out, col_en_host, col_sel_host}, m_data); end
      #1;
      rst_n = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_release got s_ready=%b busy=%b want 1 0", s_ready, busy); end
      tick();
      load_and_start(EXP_IN);
      read_out();
      checks++; if (m_valid !== 1'b1 || m_data !== EXP_OUT) begin errors++; $display("FAIL mid_rst_next got v=%b d=%h want 1 %h", m_valid, m_data, EXP_OUT); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   // Twelve edges between handshakes: one IDLE cycle plus eleven busy cycles.
   task automatic test_back_to_back();
      int hs [2];
      int nhs = 0;
      int nout = 0;
      logic seen_start = 1'b0;
      s_valid = 1'b1;
      s_data  = EXP_IN;
      m_ready = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         end_aes    = seen_start;
         seen_start = start;
         if (m_valid) begin
            checks++; if (m_data !== EXP_OUT) begin errors++; $display("FAIL b2b_m_data[%0d] got %h want %h", nout, m_data, EXP_OUT); end
            nout++;
         end
         if (s_valid && s_ready && nhs < 2) begin
            hs[nhs] = cyc;
            nhs++;
         end
         tick();
         if (nhs == 1) s_data = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
         if (nhs == 2) s_valid = 1'b0;
      end
      end_aes = 1'b0;
      m_ready = 1'b0;
      checks++; if (nhs !== 2) begin errors++; $display("FAIL b2b_handshakes got %0d want 2", nhs); end
      checks++; if (nhs == 2 && hs[1] - hs[0] !== 12) begin errors++; $display("FAIL b2b_spacing got %0d want 12", hs[1] - hs[0]); end
      checks++; if (nout !== 2) begin errors++; $display("FAIL b2b_outputs got %0d want 2", nout); end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_backpressure();
      test_timeout();
      test_spurious_end();
      test_reset_mid_read();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
